// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch-resolve queue.
package bp_pkg;
    localparam int BP_AW      = 32;
    localparam int INSN_BYTES = 4;
    typedef struct packed {
        logic [BP_AW-1:0] pc;
        logic             hit;
        logic             taken;
        logic [BP_AW-1:0] target;
    } bp_pred_entry_t;
endpackage

// File: rtl/bp_pred_fifo.sv
// bp_pred_fifo: circular prediction buffer with push/pop/clear; full/empty derive from the count.
module bp_pred_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = bp_pred_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   clear,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int PW = $clog2(DEPTH);
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_en, pop_en;
    always_comb begin
        full     = count_q == (PW+1)'(DEPTH);
        empty    = count_q == '0;
        pop_en   = pop & ~empty;
        // a full queue still takes a push when the head leaves in the same cycle
        push_en  = push & (~full | pop_en);
        wr_ptr_d = clear ? '0 : wr_ptr_q + PW'(push_en);
        rd_ptr_d = clear ? '0 : rd_ptr_q + PW'(pop_en);
        count_d  = clear ? '0 : count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
        head     = mem_q[rd_ptr_q];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: pairs fetch predictions with execute outcomes, drives BTB update and redirect.
// Optional BP_PERF_CNT_EN adds perf_resolved/perf_mispred counters.
module bp_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = BP_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_valid,
    output logic          pred_ready,
    input  logic [AW-1:0] pred_pc,
    input  logic          pred_hit,
    input  logic          pred_taken,
    input  logic [AW-1:0] pred_target,
    input  logic          res_valid,
    input  logic          res_taken,
    input  logic [AW-1:0] res_target,
    input  logic          flush,
    output logic          upd_valid,
    output logic [AW-1:0] upd_pc,
    output logic [AW-1:0] upd_target,
    output logic          redirect_valid,
    output logic [AW-1:0] redirect_pc,
    output logic          res_err
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]   perf_resolved,
    output logic [31:0]   perf_mispred
`endif
);
    typedef struct packed {
        logic [AW-1:0] pc;
        logic          hit;
        logic          taken;
        logic [AW-1:0] target;
    } entry_t;
    entry_t        push_data, head;
    logic          full, empty, push, pop, p_t, mis, clear;
    logic [AW-1:0] fix_pc;
    logic          ready_q, ready_d, upd_valid_q, upd_valid_d, res_err_q, res_err_d;
    logic [AW-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
    bp_pred_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );
    always_comb begin
        push_data    = '{pc: pred_pc, hit: pred_hit, taken: pred_taken, target: pred_target};
        push         = pred_valid & ready_q;
        // flush wins over a same-cycle resolve, so that pop never reports
        pop          = res_valid & ~empty & ~flush;
        p_t          = head.hit & head.taken;
        mis          = pop & ((p_t != res_taken) | (p_t & res_taken & (head.target != res_target)));
        fix_pc       = res_taken ? res_target : head.pc + AW'(INSN_BYTES);
        clear        = flush | mis;
        ready_d      = 1'b1;
        upd_valid_d  = mis;
        upd_pc_d     = mis ? head.pc : upd_pc_q;
        upd_target_d = mis ? fix_pc : upd_target_q;
        res_err_d    = res_err_q | (res_valid & empty);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q      <= 1'b0;
            upd_valid_q  <= 1'b0;
            upd_pc_q     <= '0;
            upd_target_q <= '0;
            res_err_q    <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            upd_valid_q  <= upd_valid_d;
            upd_pc_q     <= upd_pc_d;
            upd_target_q <= upd_target_d;
            res_err_q    <= res_err_d;
        end
    end
    always_comb begin
        pred_ready     = ready_q & ~full;
        upd_valid      = upd_valid_q;
        upd_pc         = upd_pc_q;
        upd_target     = upd_target_q;
        redirect_valid = upd_valid_q;
        redirect_pc    = upd_target_q;
        res_err        = res_err_q;
    end
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_resolved_q, perf_resolved_d, perf_mispred_q, perf_mispred_d;
    always_comb begin
        perf_resolved_d = perf_resolved_q + 32'(pop);
        perf_mispred_d  = perf_mispred_q + 32'(mis);
        perf_resolved   = perf_resolved_q;
        perf_mispred    = perf_mispred_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_resolved_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_resolved_q <= perf_resolved_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end
`endif
endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue: directed stimulus with a strobe scoreboard drained by a negedge monitor.
module tb_bp_resolve_queue;
    logic        clk = 1'b0, rst = 1'b0;
    logic        pred_valid = 1'b0, pred_hit = 1'b0, pred_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
    logic [31:0] res_target = '0;
    logic        pred_ready, upd_valid, redirect_valid, res_err;
    logic [31:0] upd_pc, upd_target, redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_resolved, perf_mispred;
`endif
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int   checks = 0, errors = 0, n_res = 0, n_mis = 0;

    bp_resolve_queue #(.DEPTH(8), .AW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_pc        (pred_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .flush          (flush),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .res_err        (res_err)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_resolved  (perf_resolved),
        .perf_mispred   (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && (upd_valid || redirect_valid)) begin
            if (sb.size() == 0) chk("spurious_strobe", {31'b0, upd_valid | redirect_valid}, 32'h0);
            else begin
                e = sb.pop_front();
                chk("upd_valid", {31'b0, upd_valid}, 32'h1);
                chk("redirect_valid", {31'b0, redirect_valid}, 32'h1);
                chk("upd_pc", upd_pc, e.pc);
                chk("upd_target", upd_target, e.tgt);
                chk("redirect_pc", redirect_pc, e.tgt);
            end
        end
    end

    task automatic step(input logic pv, input logic [31:0] ppc, input logic ph, input logic pt,
                        input logic [31:0] ptg, input logic rv, input logic rt,
                        input logic [31:0] rtg, input logic fl);
        pred_valid = pv; pred_pc = ppc; pred_hit = ph; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg; flush = fl;
        @(posedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
        step(1'b1, pc, h, t, tg, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic res_ok(input logic t, input logic [31:0] tg);
        n_res++;
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, t, tg, 1'b0);
    endtask

    task automatic res_bad(input logic t, input logic [31:0] tg, input logic [31:0] epc, input logic [31:0] etg);
        n_res++;
        n_mis++;
        sb.push_back('{pc: epc, tgt: etg});
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, t, tg, 1'b0);
    endtask

    task automatic cnt(input string name, input int exp);
        chk(name, 32'(dut.u_fifo.count_q), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pred_ready", {31'b0, pred_ready}, 32'h0);
        chk("rst_upd_valid", {31'b0, upd_valid}, 32'h0);
        chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("rst_res_err", {31'b0, res_err}, 32'h0);
        cnt("rst_count", 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'b0, pred_ready}, 32'h1);
        // correct taken prediction
        push(32'h100, 1'b1, 1'b1, 32'h200);
        cnt("t1_count1", 1);
        res_ok(1'b1, 32'h200);
        cnt("t1_count0", 0);
        // BTB miss, actually taken
        push(32'h100, 1'b0, 1'b0, 32'h0);
        res_bad(1'b1, 32'h180, 32'h100, 32'h180);
        // right direction, wrong target
        push(32'h300, 1'b1, 1'b1, 32'h400);
        res_bad(1'b1, 32'h404, 32'h300, 32'h404);
        // taken without hit is predicted not-taken
        push(32'h340, 1'b0, 1'b1, 32'h999);
        res_ok(1'b0, 32'h0);
        // predicted taken, resolved not-taken, younger entries flushed
        push(32'h40, 1'b1, 1'b1, 32'h80);
        push(32'h50, 1'b0, 1'b0, 32'h0);
        push(32'h60, 1'b0, 1'b0, 32'h0);
        cnt("t3_count3", 3);
        res_bad(1'b0, 32'h0, 32'h40, 32'h44);
        cnt("t3_count0", 0);
        // push during a mispredicting pop is discarded
        push(32'h700, 1'b0, 1'b0, 32'h0);
        n_res++;
        n_mis++;
        sb.push_back('{pc: 32'h700, tgt: 32'h900});
        step(1'b1, 32'h710, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h900, 1'b0);
        cnt("mis_push_count0", 0);
        // pc+4 wraps
        push(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10);
        res_bad(1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
        // offset pointers so the fill wraps
        for (int i = 0; i < 5; i++) push(32'h800 + 32'(4 * i), 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) res_ok(1'b0, '0);
        cnt("t4_count0", 0);
        for (int i = 0; i < 8; i++) push(32'h1000 + 32'(16 * i), 1'b1, 1'b1, 32'h500 + 32'(i));
        chk("full_ready", {31'b0, pred_ready}, 32'h0);
        cnt("full_count", 8);
        push(32'hDEAD0, 1'b0, 1'b0, '0);
        cnt("drop_count", 8);
        n_res++;
        step(1'b1, 32'h2000, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h500, 1'b0);
        cnt("pushpop_count", 8);
        chk("pushpop_ready", {31'b0, pred_ready}, 32'h0);
        for (int i = 1; i < 8; i++) res_ok(1'b1, 32'h500 + 32'(i));
        cnt("drain_count", 1);
        chk("drain_ready", {31'b0, pred_ready}, 32'h1);
        res_bad(1'b1, 32'h3000, 32'h2000, 32'h3000);
        // resolve on empty queue
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h123, 1'b0);
        chk("res_err_set", {31'b0, res_err}, 32'h1);
        cnt("empty_res_count", 0);
        // flush beats push and a mispredicting pop
        push(32'h900, 1'b0, 1'b0, '0);
        push(32'h904, 1'b0, 1'b0, '0);
        push(32'h908, 1'b0, 1'b0, '0);
        cnt("pre_flush_count", 3);
        step(1'b1, 32'hAAA, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h555, 1'b1);
        cnt("flush_count", 0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("res_err_sticky", {31'b0, res_err}, 32'h1);
        chk("sb_drain", 32'(sb.size()), 32'h0);
`ifdef BP_PERF_CNT_EN
        chk("perf_resolved", perf_resolved, 32'(n_res));
        chk("perf_mispred", perf_mispred, 32'(n_mis));
`endif
        // async reset while a strobe is up
        push(32'h100, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h180, 1'b0);
        chk("pre_rst_upd", {31'b0, upd_valid}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_upd_valid", {31'b0, upd_valid}, 32'h0);
        chk("arst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
        chk("arst_res_err", {31'b0, res_err}, 32'h0);
        chk("arst_ready", {31'b0, pred_ready}, 32'h0);
        cnt("arst_count", 0);
`ifdef BP_PERF_CNT_EN
        chk("arst_perf_resolved", perf_resolved, 32'h0);
        chk("arst_perf_mispred", perf_mispred, 32'h0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_arst", {31'b0, pred_ready}, 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
